// File: rtl/dmem_rsp_pkg.sv
// Shared types and constants for the dmem_rsp data-memory responder.
// Optional feature macro: DMEM_BYPASS_EN (same-cycle write-to-read forwarding).
package dmem_rsp_pkg;

  typedef enum logic {
    DMEM_ST_INIT = 1'b0,
    DMEM_ST_RUN  = 1'b1
  } dmem_state_e;

  localparam int unsigned DMEM_DW    = 32;
  localparam int unsigned DMEM_SEL_W = DMEM_DW / 8;

  // Byte-lane merge: lanes with sel set take the new byte, others keep the old byte.
  function automatic logic [DMEM_DW-1:0] lane_merge(
    input logic [DMEM_DW-1:0]    old_w,
    input logic [DMEM_DW-1:0]    new_w,
    input logic [DMEM_SEL_W-1:0] sel
  );
    logic [DMEM_DW-1:0] res;
    res = old_w;
    for (int k = 0; k < DMEM_SEL_W; k++) begin
      if (sel[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// RD_LAT-deep valid/data/err delay line; the last stage drives the response outputs.
module dmem_rsp_pipe
  import dmem_rsp_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld_i,
  input  logic [DMEM_DW-1:0] data_i,
  input  logic               err_i,
  output logic               vld_o,
  output logic [DMEM_DW-1:0] data_o,
  output logic               err_o
);

  logic [RD_LAT-1:0]              vld_q;
  logic [RD_LAT-1:0]              err_q;
  logic [RD_LAT-1:0][DMEM_DW-1:0] data_q;

  // No backpressure: every stage advances every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      err_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      err_q[0]  <= err_i;
      data_q[0] <= data_i;
      for (int k = RD_LAT - 1; k > 0; k--) begin
        vld_q[k]  <= vld_q[k-1];
        err_q[k]  <= err_q[k-1];
        data_q[k] <= data_q[k-1];
      end
    end
  end

  assign vld_o  = vld_q[RD_LAT-1];
  assign err_o  = err_q[RD_LAT-1];
  assign data_o = data_q[RD_LAT-1];

endmodule

// File: rtl/dmem_rsp.sv
// Data-memory responder: zeroes the array after reset, then serves reads/stores.
// Define DMEM_BYPASS_EN for write-first same-word forwarding; default is read-first.
module dmem_rsp
  import dmem_rsp_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_rd_req_i,
  input  logic [31:0]           mem_rd_addr_i,
  input  logic                  mem_wr_req_i,
  input  logic [31:0]           mem_wr_addr_i,
  input  logic [DMEM_DW-1:0]    mem_wr_data_i,
  input  logic [DMEM_SEL_W-1:0] mem_wr_sel_i,
  output logic                  mem_rd_vld_o,
  output logic [DMEM_DW-1:0]    mem_rd_data_o,
  output logic                  mem_rd_err_o,
  output logic                  busy_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  dmem_state_e        state_q;
  logic [AW-1:0]      init_cnt_q;
  logic               busy_q;
  logic [DMEM_DW-1:0] mem_q [DEPTH];

  logic               run;
  logic               rd_in_range;
  logic               wr_in_range;
  logic [AW-1:0]      rd_idx;
  logic [AW-1:0]      wr_idx;
  logic               rd_acc;
  logic               wr_en;
  logic [DMEM_DW-1:0] old_word;
  logic [DMEM_DW-1:0] rd_word;
  logic [DMEM_DW-1:0] stage0_data;
  logic               stage0_err;

  assign run         = (state_q == DMEM_ST_RUN);
  assign rd_in_range = (mem_rd_addr_i < LIMIT);
  assign wr_in_range = (mem_wr_addr_i < LIMIT);
  assign rd_idx      = mem_rd_addr_i[AW+1:2];
  assign wr_idx      = mem_wr_addr_i[AW+1:2];
  assign rd_acc      = run & mem_rd_req_i;
  assign wr_en       = run & mem_wr_req_i & wr_in_range & (|mem_wr_sel_i);
  assign old_word    = mem_q[rd_idx];

`ifdef DMEM_BYPASS_EN
  assign rd_word = (wr_en && (wr_idx == rd_idx)) ?
                   lane_merge(old_word, mem_wr_data_i, mem_wr_sel_i) : old_word;
`else
  assign rd_word = old_word;
`endif

  // Data is forced to zero for idle cycles and out-of-range reads alike.
  assign stage0_data = (rd_acc && rd_in_range) ? rd_word : '0;
  assign stage0_err  = rd_acc & ~rd_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DMEM_ST_INIT;
      init_cnt_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        DMEM_ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == AW'(DEPTH - 1)) begin
            state_q <= DMEM_ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        DMEM_ST_RUN: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= DMEM_ST_INIT;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // The array itself has no reset; INIT clears it one word per cycle.
  always_ff @(posedge clk) begin
    if (state_q == DMEM_ST_INIT) begin
      mem_q[init_cnt_q] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < DMEM_SEL_W; k++) begin
        if (mem_wr_sel_i[k]) mem_q[wr_idx][8*k +: 8] <= mem_wr_data_i[8*k +: 8];
      end
    end
  end

  assign busy_o = busy_q;

  dmem_rsp_pipe #(
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_i  (rd_acc),
    .data_i (stage0_data),
    .err_i  (stage0_err),
    .vld_o  (mem_rd_vld_o),
    .data_o (mem_rd_data_o),
    .err_o  (mem_rd_err_o)
  );

endmodule

// File: tb/tb_dmem_rsp.sv
// Bench for dmem_rsp: directed scenarios plus random traffic against a byte-level memory model.
module tb_dmem_rsp;

  localparam int          DEPTH  = 64;
  localparam int          RD_LAT = 3;
  localparam logic [31:0] LIMIT  = 32'(DEPTH * 4);

  logic        clk;
  logic        rst_n;
  logic        mem_rd_req_i;
  logic [31:0] mem_rd_addr_i;
  logic        mem_wr_req_i;
  logic [31:0] mem_wr_addr_i;
  logic [31:0] mem_wr_data_i;
  logic [3:0]  mem_wr_sel_i;
  logic        mem_rd_vld_o;
  logic [31:0] mem_rd_data_o;
  logic        mem_rd_err_o;
  logic        busy_o;

  dmem_rsp #(
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_rd_req_i  (mem_rd_req_i),
    .mem_rd_addr_i (mem_rd_addr_i),
    .mem_wr_req_i  (mem_wr_req_i),
    .mem_wr_addr_i (mem_wr_addr_i),
    .mem_wr_data_i (mem_wr_data_i),
    .mem_wr_sel_i  (mem_wr_sel_i),
    .mem_rd_vld_o  (mem_rd_vld_o),
    .mem_rd_data_o (mem_rd_data_o),
    .mem_rd_err_o  (mem_rd_err_o),
    .busy_o        (busy_o)
  );

  // Clock / reset bookkeeping
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int rel_cyc = 1 << 30;
  always @(posedge clk) cyc++;

  // Reference model and scoreboard: entry = {due cycle, err, data}
  logic [31:0] ref_mem [DEPTH];
  logic [64:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit model_run();
    return (rst_n === 1'b1) && (cyc >= rel_cyc + DEPTH);
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    logic [64:0] e;
    check_eq("busy", {31'd0, busy_o}, model_run() ? 32'd0 : 32'd1);
    if (exp_q.size() > 0 && int'(exp_q[0][64:33]) == cyc) begin
      e = exp_q.pop_front();
      check_eq("rsp_vld", {31'd0, mem_rd_vld_o}, 32'd1);
      check_eq("rsp_err", {31'd0, mem_rd_err_o}, {31'd0, e[32]});
      check_eq("rsp_data", mem_rd_data_o, e[31:0]);
    end else begin
      check_eq("idle_vld", {31'd0, mem_rd_vld_o}, 32'd0);
    end
  end

  // Driver: applies one cycle of requests and updates the model as of that cycle.
  task automatic drive(input logic rd, input logic [31:0] ra, input logic wr,
                       input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] rsp;
    logic        err;
    mem_rd_req_i  = rd;
    mem_rd_addr_i = ra;
    mem_wr_req_i  = wr;
    mem_wr_addr_i = wa;
    mem_wr_data_i = wd;
    mem_wr_sel_i  = ws;
    if (model_run()) begin
      if (rd) begin
        if (ra >= LIMIT) begin
          err = 1'b1;
          rsp = 32'd0;
        end else begin
          err = 1'b0;
          rsp = ref_mem[ra / 4];
`ifdef DMEM_BYPASS_EN
          if (wr && wa < LIMIT && (wa / 4) == (ra / 4)) rsp = byte_merge(rsp, wd, ws);
`endif
        end
        exp_q.push_back({32'(cyc + RD_LAT), err, rsp});
      end
      if (wr && wa < LIMIT) ref_mem[wa / 4] = byte_merge(ref_mem[wa / 4], wd, ws);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(1'b1, a, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    drive(1'b0, 32'd0, 1'b1, a, d, s);
  endtask

  task automatic do_reset(input int n);
    mem_rd_req_i = 1'b0;
    mem_wr_req_i = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (n) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    rel_cyc = cyc;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < DEPTH + 4 && !model_run(); i++) idle();
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return LIMIT + 32'($urandom_range(0, 64));
    if (sel == 1) return $urandom() | 32'h8000_0000;
    if (sel < 6)  return 32'($urandom_range(0, 31));
    return 32'($urandom_range(0, DEPTH * 4 - 1));
  endfunction

  initial begin
    rst_n         = 1'b0;
    mem_rd_req_i  = 1'b0;
    mem_rd_addr_i = 32'd0;
    mem_wr_req_i  = 1'b0;
    mem_wr_addr_i = 32'd0;
    mem_wr_data_i = 32'd0;
    mem_wr_sel_i  = 4'd0;
    @(posedge clk);
    #1;
    check_eq("rst_vld", {31'd0, mem_rd_vld_o}, 32'd0);
    check_eq("rst_data", mem_rd_data_o, 32'd0);
    check_eq("rst_err", {31'd0, mem_rd_err_o}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd1);
    do_reset(2);

    // Init window, then first read of a zeroed word
    wait_run();
    rd(32'h10);

    // Full-word store, read at aligned and unaligned byte address
    wr(32'h8, 32'hDEAD_BEEF, 4'hF);
    rd(32'h8);
    rd(32'hB);

    // Partial-lane store
    wr(32'h40, 32'h1122_3344, 4'hF);
    wr(32'h40, 32'hAABB_CCDD, 4'b0101);
    rd(32'h40);
    wr(32'h40, 32'hFFFF_FFFF, 4'h0);
    rd(32'h40);

    // Same-cycle write/read collision, then follow-up read
    drive(1'b1, 32'h20, 1'b1, 32'h20, 32'h55, 4'h1);
    rd(32'h20);

    // Out-of-range reads and write
    wr(32'h0, 32'h1234_5678, 4'hF);
    rd(LIMIT);
    rd(32'hFFFF_FFFC);
    wr(LIMIT, 32'hFFFF_FFFF, 4'hF);
    rd(32'h0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom_range(0, 1)),
            rand_addr(), $urandom(), 4'($urandom_range(0, 15)));
    end

    // Streaming reads, then reset mid-stream
    for (int i = 0; i < 12; i++) rd(32'(4 * i));
    do_reset(3);
    for (int i = 0; i < 4; i++) idle();
    wait_run();
    rd(32'h8);
    rd(32'h40);
    repeat (RD_LAT + 2) idle();
    check_eq("drain", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
